// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: issues loads/stores over a
// req/ack data port, stalls upstream while an access is outstanding.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no access outstanding; EX/MEM sampled each cycle
// WAIT  | request issued, waiting for mem_ack or timeout
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] result,
  input  logic [31:0] writeData,
  input  logic [4:0]  rd,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] valueToWB,
  output logic [4:0]  rd_MEMWB,
  output logic        regWrite_MEMWB,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic        bus_err_q, bus_err_d;
  // write-back controls of the outstanding access, captured at issue
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_rw_q, ld_rw_d;
  logic        ld_m2r_q, ld_m2r_d;

  logic memop;
  logic illegal;
  logic last_cycle;
  logic stall_raw;

  always_comb begin
    memop      = valid & (memRead | memWrite);
    illegal    = (result[1:0] != 2'b00) | (memRead & memWrite);
    last_cycle = (cnt_q == CW'(TIMEOUT - 1));

    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_val_d    = wb_val_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    bus_err_d   = 1'b0;
    ld_rd_d     = ld_rd_q;
    ld_rw_d     = ld_rw_q;
    ld_m2r_d    = ld_m2r_q;
    stall_raw   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!valid) begin
          wb_rw_d = 1'b0;
        end else if (!memop) begin
          wb_val_d = result;
          wb_rd_d  = rd;
          wb_rw_d  = regWrite;
        end else if (illegal) begin
          bus_err_d = 1'b1;
          wb_rw_d   = 1'b0;
        end else begin
          stall_raw   = 1'b1;
          state_d     = WAIT;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = memWrite;
          mem_addr_d  = result;
          mem_wdata_d = writeData;
          wb_rw_d     = 1'b0;
          ld_rd_d     = rd;
          ld_rw_d     = regWrite;
          ld_m2r_d    = memToReg;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            // mem_addr_q still holds the EX/MEM result latched at issue
            wb_val_d = ld_m2r_q ? mem_rdata : mem_addr_q;
            wb_rd_d  = ld_rd_q;
            wb_rw_d  = ld_rw_q;
          end else begin
            wb_rw_d = 1'b0;
          end
        end else if (last_cycle) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          wb_rw_d   = 1'b0;
        end else begin
          stall_raw = 1'b1;
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_val_q    <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      ld_rd_q     <= '0;
      ld_rw_q     <= 1'b0;
      ld_m2r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_val_q    <= wb_val_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      bus_err_q   <= bus_err_d;
      ld_rd_q     <= ld_rd_d;
      ld_rw_q     <= ld_rw_d;
      ld_m2r_q    <= ld_m2r_d;
    end
  end

  assign stall          = stall_raw & rst_n;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign valueToWB      = wb_val_q;
  assign rd_MEMWB       = wb_rd_q;
  assign regWrite_MEMWB = wb_rw_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, randomized instruction stream
// against a transaction-level model, and reset/ack corner sequences.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic [31:0] result, writeData, mem_rdata, mem_addr, mem_wdata, valueToWB;
  logic [4:0]  rd, rd_MEMWB;
  logic        regWrite, memRead, memWrite, memToReg, valid;
  logic        mem_req, mem_we, mem_ack, stall, regWrite_MEMWB, bus_err;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .writeData(writeData), .rd(rd),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .valid(valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .valueToWB(valueToWB), .rd_MEMWB(rd_MEMWB), .regWrite_MEMWB(regWrite_MEMWB),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v, mr, mw, m2r, rw;
    logic [31:0] res, wd;
    logic [4:0]  rdi;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_val;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_err;
    int          exp_stall;
  } vec_t;

  // Applies one EX/MEM instruction, plays the memory side with the given ack
  // delay (cycles after the request rises, <0 = never) and returns once the
  // instruction has retired and the write-back edge has passed.
  task automatic run_instr(input vec_t t, output int stall_cnt, output int req_cnt,
                           output int req_bad, output logic req_after);
    int wcnt, guard;
    logic done;
    valid = t.v; memRead = t.mr; memWrite = t.mw; memToReg = t.m2r;
    regWrite = t.rw; result = t.res; writeData = t.wd; rd = t.rdi;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    stall_cnt = 0; req_cnt = 0; req_bad = 0; wcnt = 0; guard = 0; done = 1'b0;
    while (!done) begin
      #1;
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== t.res || mem_we !== t.mw || mem_wdata !== t.wd) req_bad++;
        if (t.delay >= 0 && wcnt == t.delay) begin
          mem_ack = 1'b1;
          mem_rdata = t.rdata;
        end
        wcnt++;
      end
      #1;
      if (stall) stall_cnt++;
      else done = 1'b1;
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      guard++;
      if (guard > 40 && !done) begin
        chk("instr_retire_bound", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    req_after = mem_req;
    valid = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t t, input logic [31:0] ev,
                           input logic [4:0] erd, input logic erw, input logic eerr,
                           input int est);
    int sc, rc, rb;
    logic ra;
    run_instr(t, sc, rc, rb, ra);
    chk({tag, "_val"},   valueToWB, ev);
    chk({tag, "_rd"},    32'(rd_MEMWB), 32'(erd));
    chk({tag, "_rw"},    32'(regWrite_MEMWB), 32'(erw));
    chk({tag, "_err"},   32'(bus_err), 32'(eerr));
    chk({tag, "_stall"}, 32'(sc), 32'(est));
    chk({tag, "_reqcyc"}, 32'(rc), 32'(est));
    chk({tag, "_reqfld"}, 32'(rb), 32'd0);
    chk({tag, "_reqoff"}, 32'(ra), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] m_val;
    logic [4:0]  m_rd;
    logic        m_rw, m_err;
    int          m_stall, kind;
    vec_t        t;

    vecs[0] = '{1,0,0,0,1, 32'h10,       32'h0,        5'd5,  -1, 32'h0,        32'h10,       5'd5,  1,0,0};
    vecs[1] = '{1,1,0,1,1, 32'h100,      32'h0,        5'd8,   3, 32'hDEADBEEF, 32'hDEADBEEF, 5'd8,  1,0,4};
    vecs[2] = '{1,0,1,0,0, 32'h204,      32'h12345678, 5'd3,   0, 32'h0,        32'hDEADBEEF, 5'd8,  0,0,1};
    vecs[3] = '{1,1,0,1,1, 32'h102,      32'h0,        5'd9,   0, 32'h0,        32'hDEADBEEF, 5'd8,  0,1,0};
    vecs[4] = '{1,1,0,1,1, 32'h300,      32'h0,        5'd10, -1, 32'h0,        32'hDEADBEEF, 5'd8,  0,1,TO};
    vecs[5] = '{1,0,0,0,1, 32'hCAFE0001, 32'h0,        5'd31, -1, 32'h0,        32'hCAFE0001, 5'd31, 1,0,0};
    vecs[6] = '{0,1,0,1,1, 32'h44,       32'h0,        5'd1,  -1, 32'h0,        32'hCAFE0001, 5'd31, 0,0,0};
    vecs[7] = '{1,1,0,0,1, 32'h40,       32'h0,        5'd7,   1, 32'h55,       32'h40,       5'd7,  1,0,2};
    vecs[8] = '{1,1,1,0,1, 32'h80,       32'h0,        5'd4,   0, 32'h0,        32'h40,       5'd7,  0,1,0};
    vecs[9] = '{1,0,0,0,0, 32'h77,       32'h0,        5'd2,  -1, 32'h0,        32'h77,       5'd2,  0,0,0};

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; memToReg = 1'b1; regWrite = 1'b1;
    result = 32'h100; writeData = 32'h0; rd = 5'd1;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_val", valueToWB, 32'd0);
    chk("rst_rd", 32'(rd_MEMWB), 32'd0);
    chk("rst_rw", 32'(regWrite_MEMWB), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      check_vec($sformatf("vec%0d", i), vecs[i], vecs[i].exp_val, vecs[i].exp_rd,
                vecs[i].exp_rw, vecs[i].exp_err, vecs[i].exp_stall);

    // Random stream; model state carries over from the last directed vector.
    m_val = vecs[9].exp_val;
    m_rd  = vecs[9].exp_rd;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      t.v = 1'b1; t.mr = 1'b0; t.mw = 1'b0;
      t.m2r = 1'($urandom_range(0, 1)); t.rw = 1'($urandom_range(0, 1));
      t.res = $urandom; t.wd = $urandom; t.rdi = 5'($urandom);
      t.rdata = $urandom; t.delay = $urandom_range(0, 5);
      if (t.delay == 5) t.delay = -1;
      case (kind)
        0: ;
        1: t.v = 1'b0;
        2: begin t.mr = 1'b1; t.res[1:0] = 2'b00; end
        3: begin t.mw = 1'b1; t.res[1:0] = 2'b00; end
        4: begin
             t.mr = 1'($urandom_range(0, 1)); t.mw = ~t.mr;
             t.res[1:0] = 2'($urandom_range(1, 3));
           end
        default: begin t.mr = 1'b1; t.mw = 1'b1; end
      endcase
      m_err = 1'b0; m_stall = 0; m_rw = 1'b0;
      if (!t.v) begin
      end else if (!(t.mr || t.mw)) begin
        m_val = t.res; m_rd = t.rdi; m_rw = t.rw;
      end else if (t.res[1:0] != 2'b00 || (t.mr && t.mw)) begin
        m_err = 1'b1;
      end else if (t.delay < 0 || t.delay >= TO) begin
        m_err = 1'b1; m_stall = TO;
      end else begin
        m_stall = t.delay + 1;
        if (t.mr) begin
          m_val = t.m2r ? t.rdata : t.res; m_rd = t.rdi; m_rw = t.rw;
        end
      end
      check_vec($sformatf("rnd%0d", n), t, m_val, m_rd, m_rw, m_err, m_stall);
    end

    // Reset on the second WAIT cycle of a load abandons it without write-back.
    t = '{1,1,0,1,1, 32'h500, 32'h0, 5'd12, -1, 32'h0, 32'h0, 5'd0, 0,0,0};
    valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; memToReg = 1'b1; regWrite = 1'b1;
    result = 32'h500; rd = 5'd12;
    tick();
    tick();
    chk("midwait_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midwait_req_drop", 32'(mem_req), 32'd0);
    chk("midwait_rw", 32'(regWrite_MEMWB), 32'd0);
    chk("midwait_stall", 32'(stall), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      // a stray ack while idle must not produce a write-back
      mem_ack = (c == 1); mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_ack = 1'b0;
      chk("postrst_rw", 32'(regWrite_MEMWB), 32'd0);
      chk("postrst_val", valueToWB, 32'd0);
      chk("postrst_req", 32'(mem_req), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
